pipeline_flush_ctrl: RTL and testbench

PIPELINE_FLUSH_CTRL -- requirements
Module: pipeline_flush_ctrl

---
 rtl/pipeline_flush_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pipeline_flush_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flush_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_flush_ctrl
//
// Purpose:
//   Generates the pipeline reset and per-stage flush controls for an in-order
//   pipeline. After system reset it holds the pipeline in reset for
//   HOLD_CYCLES clocks. In normal running it issues:
//     - a one-cycle IF (delay-slot) flush for annulled branches
//     - a one-cycle all-but-WB flush for traps
//   Requests that arrive while the pipeline is stalled, or while a flush is
//   already in progress, are remembered in one pending bit per request type.
//   They are serviced later. A trap always wins over an annul.
//
// Parameters:
//   NUM_STAGES  - pipeline stage count (bit 0 = IF, bit NUM_STAGES-1 = WB)
//   HOLD_CYCLES - post-reset hold length in clocks (1..255)
//   CNT_W       - annul statistics counter width
//
// Configuration macro:
//   FLUSH_STATS_EN - when defined, annul_count is a saturating count of
//                    entries into ANNUL; when undefined, annul_count is
//                    tied to zero.
//
// Ports:
//   clk             in   rising-edge clock
//   system_reset_n  in   asynchronous active-low system reset
//   ID_branch_instr in   branch instruction present in ID
//   a               in   annul bit of the ID branch
//   trap_req        in   trap request (flushes all stages except WB)
//   stall           in   pipeline stall, defers request consumption
//   reset_out       out  registered pipeline reset
//   flush_vec       out  registered per-stage flush
//   busy            out  high whenever the controller is not in RUN
//   annul_count     out  saturating count of annul flushes
// -----------------------------------------------------------------------------
module pipeline_flush_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  system_reset_n,
  input  logic                  ID_branch_instr,
  input  logic                  a,
  input  logic                  trap_req,
  input  logic                  stall,
  output logic                  reset_out,
  output logic [NUM_STAGES-1:0] flush_vec,
  output logic                  busy,
  output logic [CNT_W-1:0]      annul_count
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    ANNUL      = 2'd2,
    TRAP_FLUSH = 2'd3
  } state_t;

  localparam logic [7:0]            HOLD_INIT  = 8'(HOLD_CYCLES);
  localparam logic [NUM_STAGES-1:0] ALL_ONES   = {NUM_STAGES{1'b1}};
  // A trap flushes every stage except WB, so the instruction already in WB
  // still retires.
  localparam logic [NUM_STAGES-1:0] TRAP_MASK  = ALL_ONES >> 1;
  localparam logic [NUM_STAGES-1:0] ANNUL_MASK = NUM_STAGES'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_hold_cnt;
  logic [7:0]            w_hold_cnt_nxt;
  logic                  r_pend_annul;
  logic                  r_pend_trap;
  logic                  w_pend_annul_nxt;
  logic                  w_pend_trap_nxt;
  logic                  w_annul_req;
  logic                  w_eff_annul;
  logic                  w_eff_trap;
  logic                  w_reset_out_nxt;
  logic [NUM_STAGES-1:0] w_flush_nxt;
  logic                  w_busy_nxt;
  logic                  r_reset_out;
  logic [NUM_STAGES-1:0] r_flush_vec;
  logic                  r_busy;

  assign w_annul_req = ID_branch_instr & a;
  // A pending flag counts as a live request even after its input has dropped.
  assign w_eff_trap  = trap_req | r_pend_trap;
  assign w_eff_annul = w_annul_req | r_pend_annul;

  // State, hold counter and pending request registers.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state      <= RESET_HOLD;
      r_hold_cnt   <= HOLD_INIT;
      r_pend_annul <= 1'b0;
      r_pend_trap  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_pend_annul <= w_pend_annul_nxt;
      r_pend_trap  <= w_pend_trap_nxt;
    end
  end

  // Next-state, hold countdown and pending-flag update.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_pend_annul_nxt = r_pend_annul;
    w_pend_trap_nxt  = r_pend_trap;
    case (r_state)
      RESET_HOLD: begin
        // All request inputs are ignored while the hold is in progress.
        w_pend_annul_nxt = 1'b0;
        w_pend_trap_nxt  = 1'b0;
        if (r_hold_cnt <= 8'd1) begin
          w_state_nxt = RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
        end
      end
      RUN: begin
        if (stall) begin
          w_pend_trap_nxt  = r_pend_trap | trap_req;
          w_pend_annul_nxt = r_pend_annul | w_annul_req;
        end else if (w_eff_trap) begin
          // A trap supersedes any annul in the same cycle, and that annul
          // is dropped.
          w_state_nxt      = TRAP_FLUSH;
          w_pend_trap_nxt  = 1'b0;
          w_pend_annul_nxt = 1'b0;
        end else if (w_eff_annul) begin
          w_state_nxt      = ANNUL;
          w_pend_annul_nxt = 1'b0;
        end else begin
          w_state_nxt = RUN;
        end
      end
      ANNUL, TRAP_FLUSH: begin
        // Flush pulses last one cycle. New requests wait for RUN.
        w_state_nxt      = RUN;
        w_pend_trap_nxt  = r_pend_trap | trap_req;
        w_pend_annul_nxt = r_pend_annul | w_annul_req;
      end
      default: begin
        w_state_nxt = RESET_HOLD;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with
  // the state register.
  always_comb begin
    w_reset_out_nxt = 1'b0;
    w_flush_nxt     = {NUM_STAGES{1'b0}};
    w_busy_nxt      = 1'b1;
    case (w_state_nxt)
      RESET_HOLD: begin
        w_reset_out_nxt = 1'b1;
        w_flush_nxt     = ALL_ONES;
      end
      RUN: begin
        w_busy_nxt = 1'b0;
      end
      ANNUL: begin
        w_flush_nxt = ANNUL_MASK;
      end
      TRAP_FLUSH: begin
        w_flush_nxt = TRAP_MASK;
      end
      default: begin
        w_reset_out_nxt = 1'b1;
        w_flush_nxt     = ALL_ONES;
      end
    endcase
  end

  // Registered outputs. Reset drives them straight to their hold values.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_reset_out <= 1'b1;
      r_flush_vec <= ALL_ONES;
      r_busy      <= 1'b1;
    end else begin
      r_reset_out <= w_reset_out_nxt;
      r_flush_vec <= w_flush_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign reset_out = r_reset_out;
  assign flush_vec = r_flush_vec;
  assign busy      = r_busy;

`ifdef FLUSH_STATS_EN
  logic [CNT_W-1:0] r_annul_cnt;
  logic             w_annul_entry;

  assign w_annul_entry = (r_state == RUN) && (w_state_nxt == ANNUL);

  // Saturating annul statistics counter.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_annul_cnt <= {CNT_W{1'b0}};
    end else if (w_annul_entry && (r_annul_cnt != {CNT_W{1'b1}})) begin
      r_annul_cnt <= r_annul_cnt + CNT_W'(1);
    end else begin
      r_annul_cnt <= r_annul_cnt;
    end
  end

  assign annul_count = r_annul_cnt;
`else
  assign annul_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
module tb_pipeline_flush_ctrl;

  localparam int NUM_STAGES  = 5;
  localparam int HOLD_CYCLES = 3;
  localparam int CNT_W       = 2;
`ifdef FLUSH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                  clk;
  logic                  system_reset_n;
  logic                  ID_branch_instr;
  logic                  a;
  logic                  trap_req;
  logic                  stall;
  logic                  reset_out;
  logic [NUM_STAGES-1:0] flush_vec;
  logic                  busy;
  logic [CNT_W-1:0]      annul_count;

  int checks;
  int failures;

  pipeline_flush_ctrl #(
    .NUM_STAGES (NUM_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .system_reset_n (system_reset_n),
    .ID_branch_instr(ID_branch_instr),
    .a              (a),
    .trap_req       (trap_req),
    .stall          (stall),
    .reset_out      (reset_out),
    .flush_vec      (flush_vec),
    .busy           (busy),
    .annul_count    (annul_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks reset_out, flush_vec, busy and annul_count together.
  task automatic check_all(input string tag, input logic exp_rst, input logic [4:0] exp_flush,
                           input logic exp_busy, input int exp_cnt_if_enabled);
    check({tag, ".reset_out"}, 32'(reset_out), 32'(exp_rst));
    check({tag, ".flush_vec"}, 32'(flush_vec), 32'(exp_flush));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".annul_count"}, 32'(annul_count), STATS ? 32'(exp_cnt_if_enabled) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    system_reset_n = 1'b1;
    ID_branch_instr = 1'b0;
    a = 1'b0;
    trap_req = 1'b0;
    stall = 1'b0;

    // Reset is asynchronous: outputs take reset values before any clock edge.
    #2 system_reset_n = 1'b0;
    #1 check_all("async_reset", 1'b1, 5'b11111, 1'b1, 0);
    tick();
    tick();
    check_all("reset_low_2clk", 1'b1, 5'b11111, 1'b1, 0);
    system_reset_n = 1'b1;

    // Hold lasts 3 clocks after release.
    tick();
    check_all("hold_1", 1'b1, 5'b11111, 1'b1, 0);
    tick();
    check_all("hold_2", 1'b1, 5'b11111, 1'b1, 0);
    tick();
    check_all("hold_done", 1'b0, 5'b00000, 1'b0, 0);

    // Single annul.
    ID_branch_instr = 1'b1; a = 1'b1;
    tick();
    check_all("annul_pulse", 1'b0, 5'b00001, 1'b1, 1);
    ID_branch_instr = 1'b0; a = 1'b0;
    tick();
    check_all("annul_end", 1'b0, 5'b00000, 1'b0, 1);

    // Branch without annul bit: no flush.
    ID_branch_instr = 1'b1; a = 1'b0;
    tick();
    check_all("branch_no_annul", 1'b0, 5'b00000, 1'b0, 1);
    ID_branch_instr = 1'b0;

    // Trap and annul together: trap wins, annul not counted or kept.
    trap_req = 1'b1; ID_branch_instr = 1'b1; a = 1'b1;
    tick();
    check_all("trap_over_annul", 1'b0, 5'b01111, 1'b1, 1);
    trap_req = 1'b0; ID_branch_instr = 1'b0; a = 1'b0;
    tick();
    check_all("trap_end", 1'b0, 5'b00000, 1'b0, 1);
    tick();
    check_all("trap_annul_dropped", 1'b0, 5'b00000, 1'b0, 1);

    // Annul pulse during a 4-cycle stall.
    stall = 1'b1; ID_branch_instr = 1'b1; a = 1'b1;
    tick();
    check_all("stall_c1", 1'b0, 5'b00000, 1'b0, 1);
    ID_branch_instr = 1'b0; a = 1'b0;
    tick();
    check_all("stall_c2", 1'b0, 5'b00000, 1'b0, 1);
    tick();
    check_all("stall_c3", 1'b0, 5'b00000, 1'b0, 1);
    tick();
    check_all("stall_c4", 1'b0, 5'b00000, 1'b0, 1);
    stall = 1'b0;
    tick();
    check_all("stall_release_annul", 1'b0, 5'b00001, 1'b1, 2);
    tick();
    check_all("stall_release_end", 1'b0, 5'b00000, 1'b0, 2);

    // Back-to-back annul requests.
    ID_branch_instr = 1'b1; a = 1'b1;
    tick();
    check_all("b2b_first", 1'b0, 5'b00001, 1'b1, 3);
    tick();
    check_all("b2b_gap", 1'b0, 5'b00000, 1'b0, 3);
    ID_branch_instr = 1'b0; a = 1'b0;
    tick();
    check_all("b2b_second_sat", 1'b0, 5'b00001, 1'b1, 3);
    tick();
    check_all("b2b_end", 1'b0, 5'b00000, 1'b0, 3);

    // Fifth annul: the counter stays saturated.
    ID_branch_instr = 1'b1; a = 1'b1;
    tick();
    check_all("annul5_sat", 1'b0, 5'b00001, 1'b1, 3);
    ID_branch_instr = 1'b0; a = 1'b0;
    tick();

    // Trap during stall is serviced after the stall ends.
    stall = 1'b1; trap_req = 1'b1;
    tick();
    check_all("trap_stall_c1", 1'b0, 5'b00000, 1'b0, 3);
    trap_req = 1'b0;
    tick();
    check_all("trap_stall_c2", 1'b0, 5'b00000, 1'b0, 3);
    stall = 1'b0;
    tick();
    check_all("trap_pending_served", 1'b0, 5'b01111, 1'b1, 3);
    tick();
    check_all("trap_pending_end", 1'b0, 5'b00000, 1'b0, 3);

    // Reset asserted during ANNUL. Requests stay high through the hold.
    ID_branch_instr = 1'b1; a = 1'b1;
    tick();
    check_all("pre_reset_annul", 1'b0, 5'b00001, 1'b1, 3);
    #2 system_reset_n = 1'b0;
    #1 check_all("reset_mid_annul", 1'b1, 5'b11111, 1'b1, 0);
    tick();
    tick();
    system_reset_n = 1'b1;
    tick();
    check_all("rehold_1", 1'b1, 5'b11111, 1'b1, 0);
    tick();
    check_all("rehold_2", 1'b1, 5'b11111, 1'b1, 0);
    tick();
    check_all("rehold_done", 1'b0, 5'b00000, 1'b0, 0);
    ID_branch_instr = 1'b0; a = 1'b0;
    tick();
    check_all("no_pending_after_reset", 1'b0, 5'b00000, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
